cordic_chan_arbiter: RTL and testbench
======================================

Name: cordic_chan_arbiter

Overview:
Time-shares one pipelined CORDIC (pre-rotate plus rotation stages, fixed latency LAT cycles per enabled clock) between NCH requesting channels (NCO/mixer lanes).
- Round-robin grant of one request per cycle; drives the CORDIC inputs and its clock-enable.
- Carries a channel tag alongside each sample through a matching tag pipeline.
- Emits one tagged result stream with downstream backpressure, realised by freezing the whole CORDIC.

Parameters:
NCH, 4, number of requesting channels (2..8)
IW, 12, request x/y width, signed
PW, 19, phase width, unsigned full-circle
WW, 15, CORDIC result x/y width, signed
LAT, 17, CORDIC latency in enabled cycles (i_ce high), >=2
CW, $clog2(NCH), channel tag width

Ports:
i_clk  in  1  clock
i_reset_n  in  1  asynchronous active-low reset
i_req_valid  in  NCH  per-channel request valid
o_req_ready  out  NCH  one-hot accept strobe
i_req_x  in  NCH*IW  packed channel x, channel 0 in LSBs
i_req_y  in  NCH*IW  packed channel y
i_req_phase  in  NCH*PW  packed channel phase
o_cx  out  IW  CORDIC x input
o_cy  out  IW  CORDIC y input
o_cphase  out  PW  CORDIC phase input
o_cce  out  1  CORDIC clock-enable
i_rx  in  WW  CORDIC registered x output
i_ry  in  WW  CORDIC registered y output
o_res_valid  out  1  result valid
i_res_ready  in  1  downstream ready
o_res_chan  out  CW  result channel tag
o_res_x  out  WW  result x (= i_rx)
o_res_y  out  WW  result y (= i_ry)

Behaviour:
- Clock and reset: one clock, i_clk. Reset is asynchronous and active-low on i_reset_n. Reset clears the tag pipeline (valid bits vld[0..LAT-1] and tags) and sets the round-robin pointer ptr=0.
- Combinational outputs while reset is held: o_req_ready=0, o_res_valid=0, o_cce=1 so the CORDIC flushes.
- Enable: o_cce = i_res_ready | ~vld[LAT-1]. This is a stall only; data is never dropped.
- Grant, when o_cce=1 and any i_req_valid:
  - g = first valid channel scanning ptr, ptr+1, ... modulo NCH.
  - o_req_ready = 1<<g.
  - o_cx/o_cy/o_cphase = channel g's fields.
  - Next ptr = (g+1) mod NCH.
- No grant, or o_cce=0: o_req_ready=0, o_cx/o_cy/o_cphase=0, ptr holds.
- A transfer happens when i_req_valid[k] & o_req_ready[k]. Ready may depend on valid; valid must not depend on ready.
- Tag pipeline: on i_clk with o_cce=1, vld/tag shift one stage and stage 0 takes {any_grant, g}. A bubble enters with vld=0. With o_cce=0 everything holds, matching the CORDIC.
- Result outputs: o_res_valid=vld[LAT-1], o_res_chan=tag[LAT-1], o_res_x/o_res_y from i_rx/i_ry. All combinational. A result transfers when o_res_valid & i_res_ready.
- Latency: a request accepted at cycle n with o_cce high throughout appears on o_res_* at cycle n+LAT.
- Throughput: 1 result/cycle when downstream is always ready.
- Fairness: each continuously-valid channel is granted at least once every NCH grant cycles.
- Single requester: granted every enabled cycle.
- Stall while a request is pending: no grant; the requester holds its data.
- Reset mid-operation: in-flight samples are discarded (vld cleared). CORDIC residue is ignored because it is untagged.
- Width rules: no arithmetic on data; fields pass through bit-exact. ptr wraps NCH-1 -> 0.

Optional Feature:
CORDIC_ARB_PRIO0_EN
- Defined: channel 0 has strict priority. When i_req_valid[0] and o_cce=1, channel 0 is granted regardless of ptr, and ptr is not updated. The other channels stay round-robin among themselves.
- Undefined: pure round-robin as above.

Decomposition:
- Package cordic_arb_pkg: NCH, CW, LAT, widths, chan_t typedef, helper function unpacking channel k fields.
- Sub-module rr_arbiter: NCH-wide request vector plus ptr -> one-hot grant, index g, any_grant. Purely combinational, so the pointer register stays in the parent.

Test Plan:
- Reset: hold i_reset_n=0 with all requests valid -> o_req_ready=0, o_res_valid=0, o_cce=1. Release -> first grant goes to channel 0.
- Round-robin: all 4 channels valid continuously, i_res_ready=1 -> grants 0,1,2,3,0,...; o_res_chan sequence identical, starting cycle 17 after the first grant.
- Sparse: only channel 2 valid, phase=19'h25000 x=12'sd1000 -> granted every cycle. Results tagged 2 with LAT=17. Check the x/y values against the CORDIC reference model.
- Backpressure: all valid, drop i_res_ready for 5 cycles while o_res_valid=1 -> o_cce=0 and no grants for 5 cycles. Outputs are held stable, and after release no result is lost or duplicated (scoreboard by tag).
- Reset mid-stream: assert i_reset_n=0 with 10 samples in flight -> o_res_valid=0 immediately. After release, no stale result appears within LAT cycles.
- PRIO option: with CORDIC_ARB_PRIO0_EN, channels 0 and 1 valid continuously -> channel 0 always granted. Channel 1 is granted only when channel 0 drops valid.

Source files
------------

// File: rtl/cordic_chan_arbiter_pkg.sv
// Shared constants and types for the CORDIC channel arbiter: widths, tag type,
// and a helper that extracts one channel's request fields from the packed buses.
package cordic_arb_pkg;

    localparam int NCH = 4;
    localparam int IW  = 12;
    localparam int PW  = 19;
    localparam int WW  = 15;
    localparam int LAT = 17;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef logic [CW-1:0] chan_t;

    typedef struct packed {
        logic [IW-1:0] x;
        logic [IW-1:0] y;
        logic [PW-1:0] phase;
    } req_t;

    function automatic req_t chan_fields(
        input logic [NCH*IW-1:0] xb,
        input logic [NCH*IW-1:0] yb,
        input logic [NCH*PW-1:0] pb,
        input chan_t             k
    );
        req_t r;
        r.x     = xb[int'(k)*IW +: IW];
        r.y     = yb[int'(k)*IW +: IW];
        r.phase = pb[int'(k)*PW +: PW];
        return r;
    endfunction

endpackage

// File: rtl/cordic_chan_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request starting at ptr,
// wrapping modulo N. The pointer register lives in the parent.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int PTRW = 2
) (
    input  logic [N-1:0]    req,
    input  logic [PTRW-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [PTRW-1:0] idx,
    output logic            any
);

    // Scan offsets from farthest to nearest so the nearest hit overwrites.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % N]) begin
                gnt = {{(N-1){1'b0}}, 1'b1} << ((int'(ptr) + i) % N);
                idx = PTRW'((int'(ptr) + i) % N);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cordic_chan_arbiter.sv
// Time-shares one pipelined CORDIC between NCH channels with a matching tag pipeline.
// Optional macro CORDIC_ARB_PRIO0_EN gives channel 0 strict priority over the round-robin.
module cordic_chan_arbiter
    import cordic_arb_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic [NCH-1:0]      i_req_valid,
    output logic [NCH-1:0]      o_req_ready,
    input  logic [NCH*IW-1:0]   i_req_x,
    input  logic [NCH*IW-1:0]   i_req_y,
    input  logic [NCH*PW-1:0]   i_req_phase,
    output logic [IW-1:0]       o_cx,
    output logic [IW-1:0]       o_cy,
    output logic [PW-1:0]       o_cphase,
    output logic                o_cce,
    input  logic [WW-1:0]       i_rx,
    input  logic [WW-1:0]       i_ry,
    output logic                o_res_valid,
    input  logic                i_res_ready,
    output logic [CW-1:0]       o_res_chan,
    output logic [WW-1:0]       o_res_x,
    output logic [WW-1:0]       o_res_y
);

    // Handshakes: a request transfers on i_req_valid[k] & o_req_ready[k] and a
    // result on o_res_valid & i_res_ready. Ready may depend on valid, never the reverse.

    logic [LAT-1:0] vld;
    chan_t          tag [LAT];
    chan_t          ptr;

    logic [NCH-1:0] rr_gnt;
    chan_t          rr_idx;
    logic           rr_any;

    logic [NCH-1:0] gnt;
    chan_t          g;
    logic           any_grant;
    logic           hold_ptr;
    logic           grant_en;
    req_t           sel;

    rr_arbiter #(.N(NCH), .PTRW(CW)) u_rr (
        .req (i_req_valid),
        .ptr (ptr),
        .gnt (rr_gnt),
        .idx (rr_idx),
        .any (rr_any)
    );

    always_comb begin
        gnt       = rr_gnt;
        g         = rr_idx;
        any_grant = rr_any;
        hold_ptr  = 1'b0;
`ifdef CORDIC_ARB_PRIO0_EN
        // Channel 0 bypasses the pointer; with it idle the round-robin only sees 1..NCH-1.
        if (i_req_valid[0]) begin
            gnt       = {{(NCH-1){1'b0}}, 1'b1};
            g         = '0;
            any_grant = 1'b1;
            hold_ptr  = 1'b1;
        end
`endif
    end

    // The CORDIC freezes only when a finished result cannot leave; during reset it free-runs to flush.
    assign o_cce    = ~i_reset_n | i_res_ready | ~vld[LAT-1];
    assign grant_en = i_reset_n & o_cce & any_grant;

    always_comb begin
        sel = chan_fields(i_req_x, i_req_y, i_req_phase, g);
        o_req_ready = grant_en ? gnt : '0;
        o_cx        = grant_en ? sel.x : '0;
        o_cy        = grant_en ? sel.y : '0;
        o_cphase    = grant_en ? sel.phase : '0;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            vld <= '0;
            ptr <= '0;
            for (int i = 0; i < LAT; i++) tag[i] <= '0;
        end else if (o_cce) begin
            vld    <= {vld[LAT-2:0], any_grant};
            tag[0] <= g;
            for (int i = 1; i < LAT; i++) tag[i] <= tag[i-1];
            if (any_grant && !hold_ptr) begin
                if (int'(g) == NCH - 1) ptr <= '0;
                else                    ptr <= g + 1'b1;
            end
        end
    end

    assign o_res_valid = vld[LAT-1];
    assign o_res_chan  = tag[LAT-1];
    assign o_res_x     = i_rx;
    assign o_res_y     = i_ry;

endmodule

// File: tb/tb_cordic_chan_arbiter.sv
// Bench for cordic_chan_arbiter: behavioural CORDIC stand-in, accept watcher feeding
// an expected queue, and a result monitor that pops and compares.
module tb_cordic_chan_arbiter;
    import cordic_arb_pkg::*;

    localparam int EW = CW + 2 * WW;

    logic                i_clk;
    logic                i_reset_n;
    logic [NCH-1:0]      i_req_valid;
    logic [NCH-1:0]      o_req_ready;
    logic [NCH*IW-1:0]   i_req_x;
    logic [NCH*IW-1:0]   i_req_y;
    logic [NCH*PW-1:0]   i_req_phase;
    logic [IW-1:0]       o_cx;
    logic [IW-1:0]       o_cy;
    logic [PW-1:0]       o_cphase;
    logic                o_cce;
    logic [WW-1:0]       i_rx;
    logic [WW-1:0]       i_ry;
    logic                o_res_valid;
    logic                i_res_ready;
    logic [CW-1:0]       o_res_chan;
    logic [WW-1:0]       o_res_x;
    logic [WW-1:0]       o_res_y;

    cordic_chan_arbiter dut (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_x     (i_req_x),
        .i_req_y     (i_req_y),
        .i_req_phase (i_req_phase),
        .o_cx        (o_cx),
        .o_cy        (o_cy),
        .o_cphase    (o_cphase),
        .o_cce       (o_cce),
        .i_rx        (i_rx),
        .i_ry        (i_ry),
        .o_res_valid (o_res_valid),
        .i_res_ready (i_res_ready),
        .o_res_chan  (o_res_chan),
        .o_res_x     (o_res_x),
        .o_res_y     (o_res_y)
    );

    // ---------------- clock ----------------
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // ---------------- counters / scoreboard ----------------
    int n_chk  = 0;
    int n_pass = 0;
    int n_acc  = 0;
    int n_res  = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] e_mon;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Stand-in transform: any bit of x, y or phase reaching the wrong result shows up.
    function automatic logic [2*WW-1:0] cfun(input logic [IW-1:0] x, input logic [IW-1:0] y,
                                             input logic [PW-1:0] ph);
        logic [WW-1:0] rx;
        logic [WW-1:0] ry;
        rx = {{(WW-IW){x[IW-1]}}, x} ^ ph[WW-1:0];
        ry = {{(WW-IW){y[IW-1]}}, y} ^ ph[PW-1 -: WW];
        return {rx, ry};
    endfunction

    // ---------------- CORDIC stand-in: LAT enabled stages ----------------
    logic [2*WW-1:0] cpipe [LAT];
    initial for (int i = 0; i < LAT; i++) cpipe[i] = '0;
    always @(posedge i_clk) begin
        if (o_cce) begin
            for (int i = LAT - 1; i > 0; i--) cpipe[i] <= cpipe[i-1];
            cpipe[0] <= cfun(o_cx, o_cy, o_cphase);
        end
    end
    assign i_rx = cpipe[LAT-1][2*WW-1:WW];
    assign i_ry = cpipe[LAT-1][WW-1:0];

    // ---------------- channel data ----------------
    logic [IW-1:0] ch_x  [NCH];
    logic [IW-1:0] ch_y  [NCH];
    logic [PW-1:0] ch_ph [NCH];
    logic [NCH-1:0] acc_pend;

    always_comb begin
        i_req_x     = '0;
        i_req_y     = '0;
        i_req_phase = '0;
        for (int k = 0; k < NCH; k++) begin
            i_req_x[k*IW +: IW]     = ch_x[k];
            i_req_y[k*IW +: IW]     = ch_y[k];
            i_req_phase[k*PW +: PW] = ch_ph[k];
        end
    end

    // Driver: a channel presents a fresh sample after each accepted one.
    initial begin
        forever begin
            @(posedge i_clk);
            #1;
            for (int k = 0; k < NCH; k++) begin
                if (acc_pend[k]) begin
                    ch_x[k]     = ch_x[k] + 12'd13;
                    ch_y[k]     = ch_y[k] - 12'd7;
                    ch_ph[k]    = ch_ph[k] + 19'h01234;
                    acc_pend[k] = 1'b0;
                end
            end
        end
    end

    // Accept watcher: every transfer pushes its expected tagged result.
    always @(negedge i_clk) begin
        for (int k = 0; k < NCH; k++) begin
            if (i_req_valid[k] && o_req_ready[k]) begin
                exp_q.push_back({chan_t'(k), cfun(ch_x[k], ch_y[k], ch_ph[k])});
                acc_pend[k] = 1'b1;
                n_acc++;
            end
        end
    end

    // Result monitor.
    always @(negedge i_clk) begin
        if (i_reset_n && o_res_valid && i_res_ready) begin
            if (exp_q.size() == 0) begin
                chk("res_unexpected", 64'd1, 64'd0);
            end else begin
                e_mon = exp_q.pop_front();
                chk("res_chan", 64'(o_res_chan), 64'(e_mon[EW-1 -: CW]));
                chk("res_xy", 64'({o_res_x, o_res_y}), 64'(e_mon[2*WW-1:0]));
                n_res++;
            end
        end
    end

    task automatic drain(input string nm);
        int t;
        @(posedge i_clk); #1;
        i_req_valid = '0;
        t = 0;
        while (exp_q.size() != 0 && t < 80) begin
            @(negedge i_clk);
            t++;
        end
        chk({nm, "_drain_empty"}, 64'(exp_q.size()), 64'd0);
        chk({nm, "_acc_eq_res"}, 64'(n_res), 64'(n_acc));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int lat;
        i_reset_n   = 1'b0;
        i_res_ready = 1'b1;
        i_req_valid = '1;
        acc_pend    = '0;
        for (int k = 0; k < NCH; k++) begin
            ch_x[k]  = IW'(100 * (k + 1));
            ch_y[k]  = IW'(-50 * (k + 1));
            ch_ph[k] = PW'(19'h01000 * (k + 1));
        end

        // Reset held with every channel requesting.
        repeat (3) @(negedge i_clk);
        chk("rst_req_ready", 64'(o_req_ready), 64'd0);
        chk("rst_res_valid", 64'(o_res_valid), 64'd0);
        chk("rst_cce", 64'(o_cce), 64'd1);

        // Round-robin order and pipeline latency.
        @(posedge i_clk); #1;
        i_reset_n = 1'b1;
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge i_clk);
            if (i < 12) chk("rr_grant", 64'(o_req_ready), 64'(1 << (i % NCH)));
            if (lat < 0 && o_res_valid) lat = i;
        end
        chk("rr_latency", 64'(lat), 64'(LAT));

        // Backpressure: whole pipe freezes, head result stays presented.
        @(posedge i_clk); #1;
        i_res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk);
            chk("bp_cce", 64'(o_cce), 64'd0);
            chk("bp_no_grant", 64'(o_req_ready), 64'd0);
            chk("bp_hold", 64'({o_res_valid, o_res_chan, o_res_x, o_res_y}), 64'({1'b1, exp_q[0]}));
        end
        @(posedge i_clk); #1;
        i_res_ready = 1'b1;
        repeat (6) @(negedge i_clk);
        drain("bp");

        // Single requester: channel 2 granted every cycle.
        @(posedge i_clk); #1;
        ch_x[2]     = 12'sd1000;
        ch_y[2]     = -12'sd300;
        ch_ph[2]    = 19'h25000;
        i_req_valid = 4'b0100;
        for (int i = 0; i < 20; i++) begin
            @(negedge i_clk);
            chk("sparse_grant", 64'(o_req_ready), 64'h4);
            if (i == LAT - 1) chk("sparse_not_early", 64'(o_res_valid), 64'd0);
            if (i == LAT) chk("sparse_first", 64'({o_res_valid, o_res_chan, o_res_x, o_res_y}),
                              64'({1'b1, 2'd2, 15'h53E8, 15'h5BD4}));
        end
        drain("sparse");

        // Reset with samples in flight.
        @(posedge i_clk); #1;
        i_req_valid = '1;
        repeat (20) @(negedge i_clk);
        chk("mid_pre_valid", 64'(o_res_valid), 64'd1);
        @(posedge i_clk); #2;
        i_reset_n   = 1'b0;
        i_req_valid = '0;
        #1;
        chk("mid_res_valid", 64'(o_res_valid), 64'd0);
        chk("mid_req_ready", 64'(o_req_ready), 64'd0);
        chk("mid_cce", 64'(o_cce), 64'd1);
        exp_q.delete();
        n_acc = n_res;
        repeat (2) @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;
        for (int i = 0; i < LAT + 3; i++) begin
            @(negedge i_clk);
            chk("mid_no_stale", 64'(o_res_valid), 64'd0);
        end

        // Channels 0 and 1 competing, pointer known to be 0 after reset.
        @(posedge i_clk); #1;
        i_req_valid = 4'b0011;
        for (int i = 0; i < 8; i++) begin
            @(negedge i_clk);
`ifdef CORDIC_ARB_PRIO0_EN
            chk("prio_grant", 64'(o_req_ready), 64'h1);
`else
            chk("pair_grant", 64'(o_req_ready), (i % 2 == 0) ? 64'h1 : 64'h2);
`endif
        end
        @(posedge i_clk); #1;
        i_req_valid = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            chk("ch1_alone", 64'(o_req_ready), 64'h2);
        end
        drain("pair");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
